// File: rtl/wb_pkg.sv
// Shared widths and the write-buffer entry type for the write-back stage.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] value;
    } wb_entry_t;

endpackage

// File: rtl/wb_writer_if.sv
// MEM-stage to write-back handshake bundle.
interface wb_writer_if #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
);

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_wb_en;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_data;

    // MEM stage side: presents instructions, sees back-pressure.
    modport master (
        output mem_valid, mem_wb_en, mem_r_en, mem_dest, mem_alu_result, mem_data,
        input  mem_ready
    );

    // Write-back side: consumes instructions, drives back-pressure.
    modport slave (
        input  mem_valid, mem_wb_en, mem_r_en, mem_dest, mem_alu_result, mem_data,
        output mem_ready
    );

endinterface

// File: rtl/wb_fifo.sv
// Small circular write buffer. Exposes its contents in age order so the
// parent can build the pending-destination mask without knowing the pointers.
module wb_fifo import wb_pkg::*; #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output wb_entry_t        slots [DEPTH]
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; slot validity is implied by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Age-ordered view: slots[0] is the head, slots[i] valid when i < count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slots[i] = mem[PTR_W'(rd_ptr + PTR_W'(i))];
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: buffers MEM results and issues one register-file write
// per cycle from registered outputs that the register file samples on negedge.
module wb_writer #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_writer_if.slave           mem,
    input  logic                 wb_hold,
    output logic [ADDR_W-1:0]    Dest_wb,
    output logic [DATA_W-1:0]    Result_wb,
    output logic                 writeBackEn,
    output logic [2**ADDR_W-1:0] busy_mask,
    output logic [31:0]          wb_count
);

    import wb_pkg::wb_entry_t;

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        push_data;
    wb_entry_t        slots [DEPTH];
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Ready comes from the registered fill level only, so a full buffer stays
    // not-ready even in a cycle where it is also draining.
    assign mem.mem_ready = !fifo_full;
    assign fifo_push     = mem.mem_valid && mem.mem_ready && mem.mem_wb_en;
    assign fifo_pop      = !fifo_empty && !wb_hold;

    // Result select: loads write back memory data, everything else the ALU value.
    always_comb begin
        push_data.dest  = mem.mem_dest;
        push_data.value = mem.mem_r_en ? mem.mem_data : mem.mem_alu_result;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .slots     (slots)
    );

    // Output register: strobe for exactly one cycle per pop; data holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            writeBackEn <= 1'b0;
            Dest_wb     <= '0;
            Result_wb   <= '0;
            wb_count    <= '0;
        end else if (fifo_pop) begin
            writeBackEn <= 1'b1;
            Dest_wb     <= slots[0].dest;
            Result_wb   <= slots[0].value;
            wb_count    <= wb_count + 32'd1;
        end else begin
            writeBackEn <= 1'b0;
        end
    end

    // Pending-destination mask over buffered entries plus the write being issued.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < fifo_count) busy_mask[slots[i].dest] = 1'b1;
        end
        if (writeBackEn) busy_mask[Dest_wb] = 1'b1;
    end

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: inputs change 1ns after posedge, outputs are
// checked in the same window, well away from the next active edge.
module tb_wb_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_hold = 1'b0;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_wb;
    logic        writeBackEn;
    logic [15:0] busy_mask;
    logic [31:0] wb_count;

    int n_tests = 0;
    int n_fail  = 0;

    wb_writer_if bus ();

    wb_writer #(.DEPTH(2), .DATA_W(32), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (bus),
        .wb_hold     (wb_hold),
        .Dest_wb     (Dest_wb),
        .Result_wb   (Result_wb),
        .writeBackEn (writeBackEn),
        .busy_mask   (busy_mask),
        .wb_count    (wb_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] dest, input logic [31:0] alu,
                            input logic [31:0] data, input logic r_en, input logic wb_en);
        bus.mem_valid      = 1'b1;
        bus.mem_dest       = dest;
        bus.mem_alu_result = alu;
        bus.mem_data       = data;
        bus.mem_r_en       = r_en;
        bus.mem_wb_en      = wb_en;
        step();
        bus.mem_valid      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_tests++; if (writeBackEn !== 1'b0) begin n_fail++; $display("FAIL reset_wben: got %0h want 0", writeBackEn); end
        n_tests++; if (Dest_wb !== 4'h0) begin n_fail++; $display("FAIL reset_dest: got %0h want 0", Dest_wb); end
        n_tests++; if (Result_wb !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %0h want 0", Result_wb); end
        n_tests++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy_mask); end
        n_tests++; if (wb_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0h want 0", wb_count); end
        n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0h want 1", bus.mem_ready); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_alu();
        push_one(4'd3, 32'h0000_00AA, 32'h0, 1'b0, 1'b1);
        n_tests++; if (writeBackEn !== 1'b0) begin n_fail++; $display("FAIL alu_wben_early: got %0h want 0", writeBackEn); end
        n_tests++; if (busy_mask !== 16'h0008) begin n_fail++; $display("FAIL alu_busy_queued: got %0h want 0008", busy_mask); end
        step();
        n_tests++; if (writeBackEn !== 1'b1) begin n_fail++; $display("FAIL alu_wben: got %0h want 1", writeBackEn); end
        n_tests++; if (Dest_wb !== 4'd3) begin n_fail++; $display("FAIL alu_dest: got %0h want 3", Dest_wb); end
        n_tests++; if (Result_wb !== 32'h0000_00AA) begin n_fail++; $display("FAIL alu_result: got %0h want aa", Result_wb); end
        n_tests++; if (wb_count !== 32'd1) begin n_fail++; $display("FAIL alu_count: got %0d want 1", wb_count); end
        n_tests++; if (busy_mask !== 16'h0008) begin n_fail++; $display("FAIL alu_busy_issue: got %0h want 0008", busy_mask); end
        step();
        n_tests++; if (writeBackEn !== 1'b0) begin n_fail++; $display("FAIL alu_wben_after: got %0h want 0", writeBackEn); end
        n_tests++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL alu_busy_after: got %0h want 0", busy_mask); end
        n_tests++; if (Dest_wb !== 4'd3) begin n_fail++; $display("FAIL alu_dest_hold: got %0h want 3", Dest_wb); end
    endtask

    task automatic test_load();
        push_one(4'd5, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step();
        n_tests++; if (writeBackEn !== 1'b1) begin n_fail++; $display("FAIL load_wben: got %0h want 1", writeBackEn); end
        n_tests++; if (Dest_wb !== 4'd5) begin n_fail++; $display("FAIL load_dest: got %0h want 5", Dest_wb); end
        n_tests++; if (Result_wb !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_result: got %0h want deadbeef", Result_wb); end
        n_tests++; if (wb_count !== 32'd2) begin n_fail++; $display("FAIL load_count: got %0d want 2", wb_count); end
        step();
    endtask

    task automatic test_hold();
        wb_hold = 1'b1;
        push_one(4'd1, 32'h11, 32'h0, 1'b0, 1'b1);
        push_one(4'd2, 32'h22, 32'h0, 1'b0, 1'b1);
        n_tests++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready_full: got %0h want 0", bus.mem_ready); end
        n_tests++; if (busy_mask !== 16'h0006) begin n_fail++; $display("FAIL hold_busy: got %0h want 0006", busy_mask); end
        n_tests++; if (writeBackEn !== 1'b0) begin n_fail++; $display("FAIL hold_wben: got %0h want 0", writeBackEn); end
        push_one(4'd9, 32'h99, 32'h0, 1'b0, 1'b1);
        n_tests++; if (busy_mask !== 16'h0006) begin n_fail++; $display("FAIL hold_third_rejected: got %0h want 0006", busy_mask); end
        wb_hold = 1'b0;
        n_tests++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready_full_pop: got %0h want 0", bus.mem_ready); end
        step();
        n_tests++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd1 || Result_wb !== 32'h11) begin n_fail++; $display("FAIL hold_first: got en=%0h d=%0h r=%0h want en=1 d=1 r=11", writeBackEn, Dest_wb, Result_wb); end
        n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_after: got %0h want 1", bus.mem_ready); end
        step();
        n_tests++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd2 || Result_wb !== 32'h22) begin n_fail++; $display("FAIL hold_second: got en=%0h d=%0h r=%0h want en=1 d=2 r=22", writeBackEn, Dest_wb, Result_wb); end
        step();
        n_tests++; if (writeBackEn !== 1'b0 || Dest_wb !== 4'd2) begin n_fail++; $display("FAIL hold_drained: got en=%0h d=%0h want en=0 d=2", writeBackEn, Dest_wb); end
        n_tests++; if (wb_count !== 32'd4) begin n_fail++; $display("FAIL hold_count: got %0d want 4", wb_count); end
        n_tests++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL hold_busy_clear: got %0h want 0", busy_mask); end
    endtask

    task automatic test_back_to_back();
        push_one(4'd7, 32'd1, 32'h0, 1'b0, 1'b1);
        push_one(4'd7, 32'd2, 32'h0, 1'b0, 1'b1);
        n_tests++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd7 || Result_wb !== 32'd1) begin n_fail++; $display("FAIL b2b_first: got en=%0h d=%0h r=%0h want en=1 d=7 r=1", writeBackEn, Dest_wb, Result_wb); end
        n_tests++; if (busy_mask !== 16'h0080) begin n_fail++; $display("FAIL b2b_busy1: got %0h want 0080", busy_mask); end
        step();
        n_tests++; if (writeBackEn !== 1'b1 || Result_wb !== 32'd2) begin n_fail++; $display("FAIL b2b_second: got en=%0h r=%0h want en=1 r=2", writeBackEn, Result_wb); end
        n_tests++; if (busy_mask !== 16'h0080) begin n_fail++; $display("FAIL b2b_busy2: got %0h want 0080", busy_mask); end
        step();
        n_tests++; if (writeBackEn !== 1'b0 || Result_wb !== 32'd2) begin n_fail++; $display("FAIL b2b_idle: got en=%0h r=%0h want en=0 r=2", writeBackEn, Result_wb); end
        n_tests++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL b2b_busy_clear: got %0h want 0", busy_mask); end
        n_tests++; if (wb_count !== 32'd6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", wb_count); end
    endtask

    task automatic test_no_wb();
        push_one(4'd4, 32'h44, 32'h0, 1'b0, 1'b0);
        n_tests++; if (busy_mask !== 16'h0) begin n_fail++; $display("FAIL nowb_busy: got %0h want 0", busy_mask); end
        step();
        n_tests++; if (writeBackEn !== 1'b0) begin n_fail++; $display("FAIL nowb_wben: got %0h want 0", writeBackEn); end
        n_tests++; if (wb_count !== 32'd6) begin n_fail++; $display("FAIL nowb_count: got %0d want 6", wb_count); end
        n_tests++; if (Dest_wb !== 4'd7 || Result_wb !== 32'd2) begin n_fail++; $display("FAIL nowb_hold_outputs: got d=%0h r=%0h want d=7 r=2", Dest_wb, Result_wb); end
        n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL nowb_ready: got %0h want 1", bus.mem_ready); end
    endtask

    task automatic test_reset_pending();
        wb_hold = 1'b1;
        push_one(4'd10, 32'hA0, 32'h0, 1'b0, 1'b1);
        push_one(4'd11, 32'hB0, 32'h0, 1'b0, 1'b1);
        wb_hold = 1'b0;
        step();
        n_tests++; if (writeBackEn !== 1'b1 || Dest_wb !== 4'd10 || Result_wb !== 32'hA0) begin n_fail++; $display("FAIL rstp_inflight: got en=%0h d=%0h r=%0h want en=1 d=a r=a0", writeBackEn, Dest_wb, Result_wb); end
        rst = 1'b0;
        step();
        n_tests++; if (writeBackEn !== 1'b0 || Dest_wb !== 4'd0 || Result_wb !== 32'h0) begin n_fail++; $display("FAIL rstp_outputs: got en=%0h d=%0h r=%0h want all 0", writeBackEn, Dest_wb, Result_wb); end
        n_tests++; if (busy_mask !== 16'h0 || wb_count !== 32'h0) begin n_fail++; $display("FAIL rstp_state: got busy=%0h cnt=%0h want 0 0", busy_mask, wb_count); end
        n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL rstp_ready: got %0h want 1", bus.mem_ready); end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++; if (writeBackEn !== 1'b0 || wb_count !== 32'h0) begin n_fail++; $display("FAIL rstp_no_strobe%0d: got en=%0h cnt=%0h want 0 0", k, writeBackEn, wb_count); end
        end
    endtask

    initial begin
        bus.mem_valid      = 1'b0;
        bus.mem_wb_en      = 1'b0;
        bus.mem_r_en       = 1'b0;
        bus.mem_dest       = '0;
        bus.mem_alu_result = '0;
        bus.mem_data       = '0;
        #1;
        test_reset();
        test_alu();
        test_load();
        test_hold();
        test_back_to_back();
        test_no_wb();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning write-buffer entries (power of two, at least 2).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning result width.
REQ-003 The block SHALL have parameter ADDR_W, default 4, meaning register index width (16 registers).
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous active-low reset; rst=0 at posedge resets.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  buffer can accept this cycle.
- mem_wb_en  in  1  instruction writes a register.
- mem_r_en  in  1  instruction is a load; selects mem_data.
- mem_dest  in  ADDR_W  destination register.
- mem_alu_result  in  DATA_W  ALU result.
- mem_data  in  DATA_W  load data.
- wb_hold  in  1  suppress issuing a write this cycle.
- Dest_wb  out  ADDR_W  register file write index.
- Result_wb  out  DATA_W  register file write data.
- writeBackEn  out  1  register file write strobe.
- busy_mask  out  2**ADDR_W  bit d set while a write to register d is pending or being issued.
- wb_count  out  32  total writes issued, wrapping.

Function
REQ-006 A transfer SHALL occur when mem_valid and mem_ready are both 1 at a posedge.
REQ-007 mem_ready SHALL be 1 exactly when the stored entry count is below DEPTH, derived from registered state only; there is no combinational path from mem_valid.
REQ-008 A transfer with mem_wb_en=1 SHALL enqueue {mem_dest, mem_r_en ? mem_data : mem_alu_result}.
REQ-009 A transfer with mem_wb_en=0 SHALL be consumed with no entry and no write.
REQ-010 At each posedge where the buffer is non-empty and wb_hold=0, the head SHALL be popped into output registers, and writeBackEn SHALL be 1 for exactly the following cycle.
REQ-011 When no pop occurs, writeBackEn SHALL be 0 for the following cycle, and Dest_wb and Result_wb SHALL hold their last values.
REQ-012 The latency SHALL be one cycle: an entry accepted at posedge N into an empty buffer, with wb_hold=0 at posedge N+1, drives writeBackEn=1 between posedges N+1 and N+2.
REQ-013 Writes SHALL be issued strictly in acceptance order; two entries with the same destination SHALL both be written, in order.
REQ-014 A simultaneous enqueue and pop SHALL leave the count unchanged.
REQ-015 When the buffer is full, mem_ready SHALL be 0 even if a pop occurs that cycle.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH.
REQ-017 busy_mask SHALL be the OR of one-hot(dest) over valid buffer entries and over the output register while writeBackEn=1, computed combinationally from registered state.
REQ-018 wb_count SHALL increment by 1 per pop and wrap from 2^32-1 to 0.
REQ-019 The register file samples Dest_wb, Result_wb and writeBackEn on negedge, so all three SHALL be registered and stable from posedge to posedge.

Reset
REQ-020 rst=0 at a posedge SHALL empty the buffer and zero both pointers.
REQ-021 rst=0 at a posedge SHALL set writeBackEn=0, Dest_wb=0, Result_wb=0, busy_mask=0 and wb_count=0.
REQ-022 mem_ready SHALL be 1 in the cycle after a reset.
REQ-023 A reset during operation SHALL discard pending writes without issuing them, and a write in flight SHALL be cut off at that posedge.

Structure
REQ-024 A shared package wb_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS and the wb_entry_t struct {dest, value}.
REQ-025 The buffer SHALL be a sub-module wb_fifo (parameterized DEPTH, storing wb_entry_t with push/pop/full/empty/count), and wb_writer SHALL contain the result mux, output register, busy_mask and wb_count.

Verification
REQ-026 Scenario: single ALU op, dest=3, alu_result=0x0000_00AA, r_en=0 -> next cycle writeBackEn=1, Dest_wb=3, Result_wb=0xAA, wb_count=1, busy_mask[3]=1 while issuing.
REQ-027 Scenario: load, dest=5, mem_data=0xDEAD_BEEF, alu_result=0x100 -> Result_wb=0xDEADBEEF.
REQ-028 Scenario: wb_hold=1 while 2 entries are accepted -> mem_ready=0, a third valid is not accepted; release hold -> two consecutive writes in order, then mem_ready=1.
REQ-029 Scenario: back-to-back writes to r7 of 1 then 2 -> two strobes, the last Result_wb=2, busy_mask[7] clears after the second.
REQ-030 Scenario: mem_wb_en=0 transfer -> no strobe, wb_count unchanged.
REQ-031 Scenario: rst=0 with 2 pending entries -> no further strobes, all outputs 0, mem_ready=1 the cycle after reset.
